// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width: enough to count WIDTH serial steps, never narrower than 1.
    function automatic int cnt_w(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/half_subtractor.sv
// Single-bit half subtractor: x - y, difference and borrow-out.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);

    // Pure combinational cell; two of these plus an OR form a full subtractor.
    always_comb begin
        d  = x ^ y;
        bo = ~x & y;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first unsigned subtractor: diff = a - b, borrow = (a < b).
// One bit per clock through a full-subtractor cell with a registered borrow.
// Optional macro SERIAL_SUBTRACTOR_OVERFLOW_EN adds a signed-overflow output.
//
// Handshake: a word transfers on any rising edge where valid and ready are both
// high. in_ready is high only in IDLE; out_valid is high only in DONE and, once
// raised, diff/borrow stay stable until the edge where out_ready is sampled high.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    import serial_sub_pkg::*;

    localparam int             CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] sa, sb, res, res_n;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             d1, bo1, d, bo2, bo;
    logic             last;
    logic             accept;

    half_subtractor u_hs0 (.x(sa[0]), .y(sb[0]), .d(d1), .bo(bo1));
    half_subtractor u_hs1 (.x(d1),    .y(br),    .d(d),  .bo(bo2));

    assign bo       = bo1 | bo2;
    assign last     = (cnt == LAST);
    assign in_ready = (state == IDLE);
    assign accept   = in_valid & in_ready;

    // Result shifts right with the new difference bit entering at the MSB.
    always_comb begin
        res_n            = res >> 1;
        res_n[WIDTH-1]   = d;
    end

    // Next-state decode.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid)  state_n = RUN;
            RUN:     if (last)      state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default:                state_n = IDLE;
        endcase
    end

    // State register; out_valid is registered directly from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            out_valid <= (state_n == DONE);
        end
    end

    // Operand shift registers, borrow chain, bit counter and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sa  <= a;
                        sb  <= b;
                        res <= '0;
                        cnt <= '0;
                        br  <= 1'b0;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= res_n;
                    br  <= bo;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        diff   <= res_n;
                        borrow <= bo;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic a_msb, b_msb;

    // Signed overflow from the captured operand MSBs and the final difference bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
            end
            if (state == RUN && last) begin
                overflow <= (a_msb != b_msb) & (d != a_msb);
            end
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH 8, 4 and 1.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       in_valid8, in_ready8, out_valid8, out_ready8, borrow8;
    logic [7:0] a8, b8, diff8;
    // WIDTH=4 instance
    logic       in_valid4, in_ready4, out_valid4, out_ready4, borrow4;
    logic [3:0] a4, b4, diff4;
    // WIDTH=1 instance
    logic       in_valid1, in_ready1, out_valid1, out_ready1, borrow1;
    logic       a1, b1, diff1;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic       ovf8, ovf4, ovf1;
`endif

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .diff(diff8), .borrow(borrow8)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        , .overflow(ovf8)
`endif
    );

    serial_subtractor #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
        .diff(diff4), .borrow(borrow4)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        , .overflow(ovf4)
`endif
    );

    serial_subtractor #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
        .diff(diff1), .borrow(borrow1)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        , .overflow(ovf1)
`endif
    );

    // Global watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // One full WIDTH=8 transaction: accept, latency, result, hand-off.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] ed, input logic eb, input string tag);
        int lat;
        lat = 0;
        @(negedge clk);
        n_cmp++;
        if (in_ready8 !== 1'b1) begin
            n_bad++;
            $display("FAIL %s in_ready: got %b want 1", tag, in_ready8);
        end
        in_valid8 = 1'b1; a8 = av; b8 = bv;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        do begin
            @(posedge clk); lat++;
            @(negedge clk);
        end while (out_valid8 !== 1'b1 && lat < 20);
        n_cmp++;
        if (lat != 8) begin
            n_bad++;
            $display("FAIL %s latency: got %0d want 8", tag, lat);
        end
        n_cmp++;
        if (diff8 !== ed) begin
            n_bad++;
            $display("FAIL %s diff: got %h want %h", tag, diff8, ed);
        end
        n_cmp++;
        if (borrow8 !== eb) begin
            n_bad++;
            $display("FAIL %s borrow: got %b want %b", tag, borrow8, eb);
        end
        out_ready8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready8 = 1'b0;
        n_cmp++;
        if ({out_valid8, in_ready8} !== 2'b01) begin
            n_bad++;
            $display("FAIL %s handoff: got out_valid=%b in_ready=%b want 0 1", tag, out_valid8, in_ready8);
        end
    endtask

    // One full WIDTH=1 transaction.
    task automatic run1(input logic av, input logic bv, input logic ed, input logic eb, input string tag);
        int lat;
        lat = 0;
        @(negedge clk);
        in_valid1 = 1'b1; a1 = av; b1 = bv;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        do begin
            @(posedge clk); lat++;
            @(negedge clk);
        end while (out_valid1 !== 1'b1 && lat < 10);
        n_cmp++;
        if (lat != 1) begin
            n_bad++;
            $display("FAIL %s latency: got %0d want 1", tag, lat);
        end
        n_cmp++;
        if ({borrow1, diff1} !== {eb, ed}) begin
            n_bad++;
            $display("FAIL %s result: got diff=%b borrow=%b want diff=%b borrow=%b", tag, diff1, borrow1, ed, eb);
        end
        out_ready1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready1 = 1'b0;
        n_cmp++;
        if ({out_valid1, in_ready1} !== 2'b01) begin
            n_bad++;
            $display("FAIL %s handoff: got out_valid=%b in_ready=%b want 0 1", tag, out_valid1, in_ready1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0;
        in_valid4 = 0; out_ready4 = 0; a4 = 0; b4 = 0;
        in_valid1 = 0; out_ready1 = 0; a1 = 0; b1 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({out_valid8, in_ready8, borrow8, diff8} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
            n_bad++;
            $display("FAIL reset_w8: got ov=%b ir=%b br=%b diff=%h want 0 1 0 00",
                     out_valid8, in_ready8, borrow8, diff8);
        end
        n_cmp++;
        if ({out_valid4, in_ready4, borrow4, diff4} !== {1'b0, 1'b1, 1'b0, 4'h0}) begin
            n_bad++;
            $display("FAIL reset_w4: got ov=%b ir=%b br=%b diff=%h want 0 1 0 0",
                     out_valid4, in_ready4, borrow4, diff4);
        end
        n_cmp++;
        if ({out_valid1, in_ready1, borrow1, diff1} !== 4'b0100) begin
            n_bad++;
            $display("FAIL reset_w1: got ov=%b ir=%b br=%b diff=%b want 0 1 0 0",
                     out_valid1, in_ready1, borrow1, diff1);
        end
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        n_cmp++;
        if (ovf8 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_overflow: got %b want 0", ovf8);
        end
`endif
    endtask

    task automatic test_directed();
        run8(8'h05, 8'h03, 8'h02, 1'b0, "d_05_03");
        run8(8'h03, 8'h05, 8'hFE, 1'b1, "d_03_05");
        run8(8'hFF, 8'hFF, 8'h00, 1'b0, "d_ff_ff");
        run8(8'h00, 8'h01, 8'hFF, 1'b1, "d_00_01");
        run8(8'h00, 8'h00, 8'h00, 1'b0, "d_00_00");
    endtask

    task automatic test_backpressure();
        int  w;
        logic seen;
        w = 0;
        @(negedge clk);
        in_valid8 = 1'b1; a8 = 8'h05; b8 = 8'h03;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        do begin
            @(negedge clk); w++;
        end while (out_valid8 !== 1'b1 && w < 20);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({out_valid8, in_ready8, borrow8, diff8} !== {1'b1, 1'b0, 1'b0, 8'h02}) begin
                n_bad++;
                $display("FAIL bp_hold_%0d: got ov=%b ir=%b br=%b diff=%h want 1 0 0 02",
                         i, out_valid8, in_ready8, borrow8, diff8);
            end
            // A stray request while the result is pending must be ignored.
            in_valid8 = (i == 2); a8 = 8'h77; b8 = 8'h11;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid8 = 1'b0;
        n_cmp++;
        if ({out_valid8, diff8} !== {1'b1, 8'h02}) begin
            n_bad++;
            $display("FAIL bp_after_pulse: got ov=%b diff=%h want 1 02", out_valid8, diff8);
        end
        out_ready8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready8 = 1'b0;
        n_cmp++;
        if ({out_valid8, in_ready8} !== 2'b01) begin
            n_bad++;
            $display("FAIL bp_release: got ov=%b ir=%b want 0 1", out_valid8, in_ready8);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid8 === 1'b1 || in_ready8 !== 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_no_accept: got activity=%b want 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({out_valid8, in_ready8, diff8} !== {1'b0, 1'b1, 8'h00}) begin
            n_bad++;
            $display("FAIL rst_mid: got ov=%b ir=%b diff=%h want 0 1 00", out_valid8, in_ready8, diff8);
        end
        run8(8'h10, 8'h01, 8'h0F, 1'b0, "after_rst");
    endtask

    task automatic test_exhaustive4();
        logic [4:0] exp_q[$];
        int         got;
        int         cyc;
        got = 0;
        cyc = 0;
        fork
            begin
                for (int i = 0; i < 256; i++) begin
                    logic [3:0] av, bv;
                    int         w;
                    av = 4'(i >> 4);
                    bv = 4'(i);
                    w  = 0;
                    @(negedge clk);
                    while (in_ready4 !== 1'b1 && w < 100) begin
                        @(negedge clk); w++;
                    end
                    if (w >= 100) begin
                        n_cmp++; n_bad++;
                        $display("FAIL ex4_in_ready_timeout: got 0 want 1 at pair %0d", i);
                    end
                    in_valid4 = 1'b1; a4 = av; b4 = bv;
                    exp_q.push_back({av < bv, 4'(av - bv)});
                    @(posedge clk);
                    #1;
                    in_valid4 = 1'b0;
                end
            end
            begin
                while (got < 256 && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    out_ready4 = ($urandom_range(0, 3) != 0);
                    if (out_valid4 === 1'b1 && out_ready4 === 1'b1) begin
                        n_cmp++;
                        if (exp_q.size() == 0) begin
                            n_bad++;
                            $display("FAIL ex4_extra: got result diff=%h borrow=%b want none", diff4, borrow4);
                        end else begin
                            logic [4:0] e;
                            e = exp_q.pop_front();
                            if ({borrow4, diff4} !== e) begin
                                n_bad++;
                                $display("FAIL ex4_result_%0d: got diff=%h borrow=%b want diff=%h borrow=%b",
                                         got, diff4, borrow4, e[3:0], e[4]);
                            end
                        end
                        got++;
                    end
                end
                out_ready4 = 1'b0;
            end
        join
        n_cmp++;
        if (got != 256 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL ex4_count: got %0d delivered, %0d pending want 256, 0", got, exp_q.size());
        end
    endtask

    task automatic test_width1();
        run1(1'b1, 1'b0, 1'b1, 1'b0, "w1_1_0");
        run1(1'b0, 1'b1, 1'b1, 1'b1, "w1_0_1");
        run1(1'b1, 1'b1, 1'b0, 1'b0, "w1_1_1");
    endtask

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    task automatic test_overflow();
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        logic [7:0] td [3];
        logic       to [3];
        ta = '{8'h80, 8'h7F, 8'h05};
        tb = '{8'h01, 8'hFF, 8'h03};
        td = '{8'h7F, 8'h80, 8'h02};
        to = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            int w;
            w = 0;
            @(negedge clk);
            in_valid8 = 1'b1; a8 = ta[k]; b8 = tb[k];
            @(posedge clk);
            #1;
            in_valid8 = 1'b0;
            do begin
                @(negedge clk); w++;
            end while (out_valid8 !== 1'b1 && w < 20);
            n_cmp++;
            if ({ovf8, diff8} !== {to[k], td[k]}) begin
                n_bad++;
                $display("FAIL ovf_%0d: got diff=%h overflow=%b want diff=%h overflow=%b",
                         k, diff8, ovf8, td[k], to[k]);
            end
            out_ready8 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready8 = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_exhaustive4();
        test_width1();
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        test_overflow();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
